pe_accum_f32: RTL and testbench

Sequential single-precision accumulator for the processing element. Consumes a stream of IEEE-754 binary32 values in groups delimited by `in_last`, reduces each group to one sum via one instance of the existing combinational `add_f32`, and presents the group result with a valid/ready handshake. Sits directly downstream of `add_f32`, closing its `sum` output back onto its `a` input through an accumulator register; output feeds the PE result path.

---
 rtl/pe_accum_f32.sv | 165 ++++++++++++++++
 tb/tb_pe_accum_f32.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pe_accum_f32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pe_accum_f32 (with combinational add_f32)                        |
// | Brief   : Sequential binary32 group accumulator with valid/ready handshake |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module add_f32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_sub, w_sticky, w_round_up;
  logic [31:0] w_big, w_sml;
  logic [7:0]  w_e_big, w_e_sml, w_diff;
  logic [26:0] w_m_big, w_m_sml, w_aligned, w_ones;
  logic [27:0] w_raw;
  logic [9:0]  w_exp;
  logic [24:0] w_mant;

  always_comb begin
    sum        = 32'd0;
    w_a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    w_b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    w_a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    w_swap     = (b[30:0] > a[30:0]);
    w_big      = w_swap ? b : a;
    w_sml      = w_swap ? a : b;
    // Denormals use exponent 1 with no hidden bit; 3 extra bits carry guard/round/sticky.
    w_e_big    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_e_sml    = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_m_big    = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
    w_m_sml    = {(w_sml[30:23] != 8'd0), w_sml[22:0], 3'b000};
    w_diff     = w_e_big - w_e_sml;
    w_ones     = '1;
    if (w_diff >= 8'd27) begin
      w_aligned = 27'd0;
      w_sticky  = |w_m_sml;
    end else begin
      w_aligned = w_m_sml >> w_diff;
      w_sticky  = |(w_m_sml & ~(w_ones << w_diff));
    end
    w_aligned[0] = w_aligned[0] | w_sticky;
    w_sub      = w_big[31] ^ w_sml[31];
    w_raw      = w_sub ? ({1'b0, w_m_big} - {1'b0, w_aligned})
                       : ({1'b0, w_m_big} + {1'b0, w_aligned});
    w_exp      = {2'b00, w_e_big};
    if (w_raw[27]) begin
      w_raw = {1'b0, w_raw[27:2], w_raw[1] | w_raw[0]};
      w_exp = w_exp + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!w_raw[26] && (w_exp > 10'd1)) begin
          w_raw = w_raw << 1;
          w_exp = w_exp - 10'd1;
        end
      end
    end
    // Round to nearest, ties to even.
    w_round_up = w_raw[2] && (w_raw[1] || w_raw[0] || w_raw[3]);
    w_mant     = {1'b0, w_raw[26:3]} + {24'd0, w_round_up};
    if (w_mant[24]) begin
      w_mant = {1'b0, w_mant[24:1]};
      w_exp  = w_exp + 10'd1;
    end

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31]))) begin
      sum = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      sum = a;
    end else if (w_b_inf) begin
      sum = b;
    end else if (w_raw == 28'd0) begin
      sum = {a[31] & b[31], 31'd0};
    end else if (w_exp >= 10'd255) begin
      sum = {w_big[31], 8'hFF, 23'd0};
    end else if (!w_mant[23]) begin
      sum = {w_big[31], 8'd0, w_mant[22:0]};
    end else begin
      sum = {w_big[31], w_exp[7:0], w_mant[22:0]};
    end
  end
endmodule

module pe_accum_f32 #(
  parameter int WIDTH      = 32,
  parameter int COUNTWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [COUNTWIDTH-1:0] out_count
);
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                r_state, w_state_next;
  logic [WIDTH-1:0]      r_acc, w_acc_next, w_sum;
  logic [COUNTWIDTH-1:0] r_count, w_count_next;
  logic                  r_first, w_first_next, w_accept;

  add_f32 u_add (
    .a   (r_acc),
    .b   (in_data),
    .sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_count <= '0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_first <= w_first_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_first_next = r_first;
    in_ready     = (r_state == ACCUM);
    out_valid    = (r_state == DONE);
    w_accept     = in_valid && in_ready;
    if (w_accept) begin
      // The first beat loads directly so single-beat groups are bit-exact.
      if (r_first) begin
        w_acc_next   = in_data;
        w_count_next = {{(COUNTWIDTH-1){1'b0}}, 1'b1};
        w_first_next = 1'b0;
      end else begin
        w_acc_next   = w_sum;
        if (r_count != {COUNTWIDTH{1'b1}}) begin
          w_count_next = r_count + 1'b1;
        end
      end
      if (in_last) begin
        w_state_next = DONE;
      end
    end
    if (out_valid && out_ready) begin
      w_state_next = ACCUM;
      w_first_next = 1'b1;
    end
  end

  assign out_data  = r_acc;
  assign out_count = r_count;
endmodule

`default_nettype wire

// File: tb/tb_pe_accum_f32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pe_accum_f32                                                  |
// | Brief   : Directed self-checking bench for pe_accum_f32                    |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module tb_pe_accum_f32;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;

  int tests = 0;
  int fails = 0;

  pe_accum_f32 #(.WIDTH(32), .COUNTWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_out_count", {24'd0, out_count}, 32'd0);
    rst = 1'b0;

    // Two-beat group with out_ready already high.
    out_ready = 1'b1;
    beat(32'h3FC00000, 1'b0);
    check("g1_no_valid_mid", {31'd0, out_valid}, 32'd0);
    beat(32'h3E800000, 1'b1);
    check("g1_out_valid", {31'd0, out_valid}, 32'd1);
    check("g1_in_ready",  {31'd0, in_ready},  32'd0);
    check("g1_data",      out_data,           32'h3FE00000);
    check("g1_count",     {24'd0, out_count}, 32'd2);
    tick();
    out_ready = 1'b0;
    check("g1_valid_drop", {31'd0, out_valid}, 32'd0);
    check("g1_ready_back", {31'd0, in_ready},  32'd1);

    // Three-beat group with a bubble.
    beat(32'h3FC00000, 1'b0);
    tick();
    beat(32'h40200000, 1'b0);
    beat(32'hBF800000, 1'b1);
    check("g2_out_valid", {31'd0, out_valid}, 32'd1);
    check("g2_data",      out_data,           32'h40400000);
    check("g2_count",     {24'd0, out_count}, 32'd3);
    handshake();

    // Output stall with input pulses that must be ignored.
    beat(32'h41A66666, 1'b0);
    beat(32'h3F99999A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b1;
      tick();
      check("g3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("g3_stall_ready", {31'd0, in_ready},  32'd0);
      check("g3_stall_data",  out_data,           32'h41B00000);
      check("g3_stall_count", {24'd0, out_count}, 32'd2);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();

    // Single-beat group followed immediately by another group.
    beat(32'hC1A66666, 1'b1);
    check("g4_data",  out_data,           32'hC1A66666);
    check("g4_count", {24'd0, out_count}, 32'd1);
    handshake();
    beat(32'h3FC00000, 1'b0);
    beat(32'h40200000, 1'b1);
    check("g5_data",  out_data,           32'h40800000);
    check("g5_count", {24'd0, out_count}, 32'd2);
    handshake();

    // Reset mid-group, then reset while DONE.
    beat(32'h3FC00000, 1'b0);
    beat(32'h40200000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("g6_ready_after_rst", {31'd0, in_ready}, 32'd1);
    check("g6_data_after_rst",  out_data,          32'd0);
    beat(32'h3E800000, 1'b1);
    check("g6_data",  out_data,           32'h3E800000);
    check("g6_count", {24'd0, out_count}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("g6_rst_done_valid", {31'd0, out_valid}, 32'd0);
    check("g6_rst_done_ready", {31'd0, in_ready},  32'd1);
    check("g6_rst_done_data",  out_data,           32'd0);
    check("g6_rst_done_count", {24'd0, out_count}, 32'd0);

    // 300 zero beats: count saturates.
    for (int i = 0; i < 300; i++) begin
      beat(32'h00000000, (i == 299));
    end
    check("g7_valid", {31'd0, out_valid}, 32'd1);
    check("g7_count", {24'd0, out_count}, 32'd255);
    check("g7_data",  out_data,           32'h00000000);
    handshake();
    check("g7_ready_back", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
